imem_loader: RTL



---
 rtl/imem_loader.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: takes a length-prefixed little-endian byte
// stream, writes 32-bit words to consecutive addresses, then releases the core.
`timescale 1ns/1ps
module imem_loader #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  // Handshake: a byte moves on a rising edge where in_valid and in_ready are both 1;
  // in_ready is registered and never depends combinationally on in_valid.

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  state_t              state, state_n;
  logic [1:0]          byte_cnt, byte_cnt_n;
  logic [ADDR_W:0]     word_cnt, word_cnt_n;
  logic [15:0]         len, len_n;
  logic [23:0]         part_q, part_n;
  logic                last_wr, last_wr_n;

  logic                in_ready_n, mem_we_n, core_rst_n_n, busy_n, done_n, err_n;
  logic [ADDR_W-1:0]   mem_adr_n;
  logic [WIDTH-1:0]    mem_wdata_n;

  logic                xfer;
  logic [15:0]         len_chk;
  logic [16:0]         next_words;

  assign xfer      = in_valid & in_ready;
  assign dbg_state = state;

  always_comb begin
    state_n      = state;
    byte_cnt_n   = byte_cnt;
    word_cnt_n   = word_cnt;
    len_n        = len;
    part_n       = part_q;
    last_wr_n    = last_wr;
    in_ready_n   = in_ready;
    mem_we_n     = 1'b0;
    mem_adr_n    = mem_adr;
    mem_wdata_n  = mem_wdata;
    core_rst_n_n = core_rst_n;
    busy_n       = busy;
    done_n       = done;
    err_n        = err;
    len_chk      = {in_data, len[7:0]};
    next_words   = 17'(word_cnt) + 17'd1;

    case (state)
      IDLE, DONE, ERR: begin
        in_ready_n = 1'b0;
        if (start) begin
          state_n      = LEN_LO;
          busy_n       = 1'b1;
          in_ready_n   = 1'b1;
          done_n       = 1'b0;
          err_n        = 1'b0;
          core_rst_n_n = 1'b0;
          word_cnt_n   = '0;
          byte_cnt_n   = '0;
          last_wr_n    = 1'b0;
        end
      end

      LEN_LO: begin
        if (xfer) begin
          len_n[7:0] = in_data;
          state_n    = LEN_HI;
        end
      end

      LEN_HI: begin
        if (xfer) begin
          len_n = len_chk;
          if (len_chk == 16'd0 || 17'(len_chk) > 17'(DEPTH)) begin
            state_n    = ERR;
            err_n      = 1'b1;
            busy_n     = 1'b0;
            in_ready_n = 1'b0;
          end else begin
            state_n = DATA;
          end
        end
      end

      DATA: begin
        if (last_wr) begin
          // Final word is on the memory port this cycle; release the core next.
          state_n      = DONE;
          last_wr_n    = 1'b0;
          done_n       = 1'b1;
          busy_n       = 1'b0;
          core_rst_n_n = 1'b1;
        end else if (xfer) begin
          byte_cnt_n = byte_cnt + 2'd1;
          case (byte_cnt)
            2'd0: part_n[7:0]   = in_data;
            2'd1: part_n[15:8]  = in_data;
            2'd2: part_n[23:16] = in_data;
            default: begin
              mem_we_n    = 1'b1;
              mem_adr_n   = word_cnt[ADDR_W-1:0];
              mem_wdata_n = {in_data, part_q};
              word_cnt_n  = next_words[ADDR_W:0];
              if (next_words == 17'(len)) begin
                in_ready_n = 1'b0;
                last_wr_n  = 1'b1;
              end
            end
          endcase
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      word_cnt   <= '0;
      len        <= '0;
      part_q     <= '0;
      last_wr    <= 1'b0;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_adr    <= '0;
      mem_wdata  <= '0;
      core_rst_n <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      byte_cnt   <= byte_cnt_n;
      word_cnt   <= word_cnt_n;
      len        <= len_n;
      part_q     <= part_n;
      last_wr    <= last_wr_n;
      in_ready   <= in_ready_n;
      mem_we     <= mem_we_n;
      mem_adr    <= mem_adr_n;
      mem_wdata  <= mem_wdata_n;
      core_rst_n <= core_rst_n_n;
      busy       <= busy_n;
      done       <= done_n;
      err        <= err_n;
    end
  end

endmodule
